// File: rtl/ra_frame_seq.sv
// Frame sequencer for the capture-memory display path: walks 2^WIN_W points from a
// trigger-aligned, offset-shifted base, stepping by the decoded zoom factor over valid/ready.
module ra_frame_seq #(
    parameter int ADDR_W    = 13,
    parameter int WIN_W     = 10,
    parameter int ZOOM_W    = 4,
    parameter int ZMAX_LOG  = 3,
    parameter int OFF_W     = 3,
    parameter int OFF_SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cont,
    input  logic [ZOOM_W-1:0] zoom,
    input  logic [OFF_W-1:0]  offset,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [WIN_W-1:0]  idx,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIN_W-1:0] LAST_IDX = '1;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] step_dec;
    logic [ADDR_W-1:0] base_dec;
    logic              accept;
    logic              last_beat;
    logic              do_latch;

    // Only powers of two up to 2^ZMAX_LOG are legal; anything else falls back to step 1.
    always_comb begin
        step_dec = ADDR_W'(1);
        for (int i = 1; i <= ZMAX_LOG; i++) begin
            if (32'(zoom) == (32'd1 << i)) begin
                step_dec = ADDR_W'(32'd1 << i);
            end
        end
    end

    assign base_dec  = trig_addr + (ADDR_W'(offset) << OFF_SHIFT);
    assign accept    = (state == RUN) && rd_ready;
    assign last_beat = accept && (idx == LAST_IDX);
    assign do_latch  = !abort && (((state == IDLE) && start) || ((state == DONE) && cont));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (cont && !abort) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are flopped from the next-state value so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            rd_valid <= (state_next == RUN);
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);
        end
    end

    // Stepping the address by z per accept is equivalent to base + idx*z modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            idx     <= '0;
            step    <= ADDR_W'(1);
        end else if (do_latch) begin
            rd_addr <= base_dec;
            idx     <= '0;
            step    <= step_dec;
        end else if (accept && !abort && !last_beat) begin
            rd_addr <= rd_addr + step;
            idx     <= idx + WIN_W'(1);
        end
    end

endmodule

// File: tb/tb_ra_frame_seq.sv
// Self-checking bench for ra_frame_seq: vector table of whole frames plus hand-written
// back-pressure, abort, reset and continuous-mode sequences, all checked by a beat scoreboard.
module tb_ra_frame_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        cont;
    logic [3:0]  zoom;
    logic [2:0]  offset;
    logic [12:0] trig_addr;
    logic        rd_ready;
    logic [12:0] rd_addr;
    logic        rd_valid;
    logic [9:0]  idx;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [12:0] addr;
        logic [9:0]  idx;
    } beat_t;

    typedef struct {
        logic [3:0]  zoom;
        logic [2:0]  off;
        logic [12:0] trig;
        logic [12:0] first;
        logic [12:0] second;
        logic [12:0] last;
    } vec_t;

    beat_t sb_q[$];
    beat_t exp_b;
    vec_t  vecs[7];

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int first_addr = -1;
    int second_addr = -1;
    int last_addr = -1;

    ra_frame_seq #(
        .ADDR_W(13), .WIN_W(10), .ZOOM_W(4), .ZMAX_LOG(3), .OFF_W(3), .OFF_SHIFT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
        .zoom(zoom), .offset(offset), .trig_addr(trig_addr), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .idx(idx), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: expected event did not occur within its cycle budget", name);
    endtask

    function automatic logic [12:0] modelStep(input logic [3:0] z);
        case (z)
            4'd1, 4'd2, 4'd4, 4'd8: return {9'd0, z};
            default:                return 13'd1;
        endcase
    endfunction

    task automatic pushFrame(input logic [3:0] z, input logic [2:0] off, input logic [12:0] trig);
        logic [12:0] base;
        logic [12:0] stp;
        beat_t b;
        base = trig + {off, 8'd0};
        stp  = modelStep(z);
        for (int i = 0; i < 1024; i++) begin
            b.addr = base + 13'(i * int'(stp));
            b.idx  = 10'(i);
            sb_q.push_back(b);
        end
    endtask

    // Called at posedge+1 in IDLE; leaves the DUT in RUN at posedge+1.
    task automatic applyStimulus(input logic [3:0] z, input logic [2:0] off, input logic [12:0] trig);
        zoom      = z;
        offset    = off;
        trig_addr = trig;
        pushFrame(z, off, trig);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc > budget) begin
                failNow("wait_idle_timeout");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic waitIdx(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (!(rd_valid && (int'(idx) == target))) begin
            if (n >= budget) begin
                failNow(tag);
                return;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int cyc;
        int d0;
        first_addr  = -1;
        second_addr = -1;
        last_addr   = -1;
        d0 = done_count;
        applyStimulus(v.zoom, v.off, v.trig);
        waitIdle(3000, cyc);
        checkOutput({tag, "_first"}, first_addr, 32'(v.first));
        checkOutput({tag, "_second"}, second_addr, 32'(v.second));
        checkOutput({tag, "_last"}, last_addr, 32'(v.last));
        checkOutput({tag, "_busy_cycles"}, cyc, 1025);
        checkOutput({tag, "_done_pulses"}, done_count - d0, 1);
        checkOutput({tag, "_sb_left"}, sb_q.size(), 0);
    endtask

    // Scoreboard: every accepted beat is compared against the next expected address/index.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_count++;
            if (rd_valid && rd_ready) begin
                if (sb_q.size() == 0) begin
                    failNow("sb_empty");
                end else begin
                    exp_b = sb_q.pop_front();
                    checkOutput("sb_addr", 32'(rd_addr), 32'(exp_b.addr));
                    checkOutput("sb_idx", 32'(idx), 32'(exp_b.idx));
                end
                if (idx == 10'd0)    first_addr  = int'(rd_addr);
                if (idx == 10'd1)    second_addr = int'(rd_addr);
                if (idx == 10'd1023) last_addr   = int'(rd_addr);
            end
        end
    end

    initial begin
        int cyc;
        int d0;
        int n;

        vecs[0] = '{4'd1, 3'd0, 13'h0000, 13'h0000, 13'h0001, 13'h03FF};
        vecs[1] = '{4'd4, 3'd3, 13'h1F00, 13'h0200, 13'h0204, 13'h11FC};
        vecs[2] = '{4'd5, 3'd0, 13'h0000, 13'h0000, 13'h0001, 13'h03FF};
        vecs[3] = '{4'd0, 3'd0, 13'h0100, 13'h0100, 13'h0101, 13'h04FF};
        vecs[4] = '{4'd8, 3'd0, 13'h1000, 13'h1000, 13'h1008, 13'h0FF8};
        vecs[5] = '{4'd2, 3'd7, 13'h0005, 13'h0705, 13'h0707, 13'h0F03};
        vecs[6] = '{4'd3, 3'd1, 13'h1FFF, 13'h00FF, 13'h0100, 13'h04FE};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cont = 1'b0;
        zoom = 4'd1;
        offset = 3'd0;
        trig_addr = 13'd0;
        rd_ready = 1'b1;

        @(negedge clk);
        checkOutput("rst_addr", 32'(rd_addr), 0);
        checkOutput("rst_valid", 32'(rd_valid), 0);
        checkOutput("rst_idx", 32'(idx), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure at idx 10 with step 2 from base 0.
        $display("[TB] back-pressure sequence");
        first_addr = -1; last_addr = -1;
        d0 = done_count;
        applyStimulus(4'd2, 3'd0, 13'd0);
        waitIdx(10, 50, "bp_wait_idx10");
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_addr", 32'(rd_addr), 20);
            checkOutput("bp_hold_idx", 32'(idx), 10);
            checkOutput("bp_hold_valid", 32'(rd_valid), 1);
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_next_addr", 32'(rd_addr), 22);
        checkOutput("bp_next_idx", 32'(idx), 11);
        waitIdle(3000, cyc);
        checkOutput("bp_last", last_addr, 32'h07FE);
        checkOutput("bp_done_pulses", done_count - d0, 1);
        checkOutput("bp_sb_left", sb_q.size(), 0);

        // Abort at idx 500: no done, back to IDLE, then a clean restart.
        $display("[TB] abort sequence");
        d0 = done_count;
        applyStimulus(4'd1, 3'd0, 13'd0);
        waitIdx(500, 600, "abort_wait_idx500");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", 32'(rd_valid), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        sb_q.delete();
        repeat (4) @(negedge clk);
        checkOutput("abort_no_done", done_count - d0, 0);
        @(posedge clk); #1;
        runVector(vecs[0], "restart");

        // Reset asserted mid-frame forces reset values immediately.
        $display("[TB] mid-frame reset sequence");
        applyStimulus(4'd4, 3'd2, 13'h0123);
        waitIdx(300, 400, "reset_wait_idx300");
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_addr", 32'(rd_addr), 0);
        checkOutput("mrst_valid", 32'(rd_valid), 0);
        checkOutput("mrst_idx", 32'(idx), 0);
        checkOutput("mrst_busy", 32'(busy), 0);
        checkOutput("mrst_done", 32'(done), 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous mode: zoom change mid-frame applies only to the next frame.
        $display("[TB] continuous sequence");
        d0 = done_count;
        first_addr = -1; second_addr = -1; last_addr = -1;
        cont = 1'b1;
        applyStimulus(4'd1, 3'd0, 13'h0040);
        waitIdx(200, 300, "cont_wait_idx200");
        zoom = 4'd2;
        pushFrame(4'd2, 3'd0, 13'h0040);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitIdx(600, 500, "cont_wait_idx600");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) failNow("cont_done_timeout");
        checkOutput("cont_bubble_valid", 32'(rd_valid), 0);
        checkOutput("cont_bubble_busy", 32'(busy), 1);
        @(negedge clk);
        checkOutput("cont_f2_valid", 32'(rd_valid), 1);
        checkOutput("cont_f2_idx", 32'(idx), 0);
        checkOutput("cont_f2_addr", 32'(rd_addr), 32'h0040);
        checkOutput("cont_f2_done_low", 32'(done), 0);
        @(posedge clk); #1;
        cont = 1'b0;
        waitIdle(3000, cyc);
        checkOutput("cont_second", second_addr, 32'h0042);
        checkOutput("cont_last", last_addr, 32'h083E);
        checkOutput("cont_done_pulses", done_count - d0, 2);
        checkOutput("cont_sb_left", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ra_frame_seq.md
# ra_frame_seq

Parametrised, sequential read-address generator for the capture-memory display path. It replaces the per-sample combinational address step with a frame sequencer. On `start` it walks one display frame of 2^WIN_W points through sample memory, stepping by the zoom factor from a trigger-aligned, offset-shifted base. Each address is issued over a valid/ready handshake to the memory read port, with abort, back-pressure and continuous-refresh support.

## Interface
- `ADDR_W`, 13: sample-memory address width; all address arithmetic is modulo 2^ADDR_W.
- `WIN_W`, 10: log2 of points per frame.
- `ZOOM_W`, 4: width of the `zoom` input.
- `ZMAX_LOG`, 3: largest legal zoom is 2^ZMAX_LOG.
- `OFF_W`, 3: width of the `offset` input.
- `OFF_SHIFT`, 8: `offset` is weighted by 2^OFF_SHIFT samples.
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled in IDLE only.
- `abort`  in  1  cancels the current frame.
- `cont`  in  1  continuous mode; sampled at each frame end.
- `zoom`  in  ZOOM_W  decimation step; latched at frame start.
- `offset`  in  OFF_W  coarse pan; latched at frame start.
- `trig_addr`  in  ADDR_W  trigger position in sample memory; latched at frame start.
- `rd_ready`  in  1  memory port accepts the current address.
- `rd_addr`  out  ADDR_W  registered read address.
- `rd_valid`  out  1  `rd_addr` is valid.
- `idx`  out  WIN_W  point index of the current `rd_addr` (display column).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse after the last point is accepted.

## Operation
- States:
  - IDLE: `rd_valid`=0.
  - RUN: `rd_valid`=1.
  - DONE: `rd_valid`=0, `done`=1.
- Zoom decode at latch time:
  - z = `zoom` if `zoom` ∈ {1, 2, 4, …, 2^ZMAX_LOG}.
  - Any other value, including 0, gives z = 1.
- Base at latch time: `base` = (`trig_addr` + (`offset` << OFF_SHIFT)) mod 2^ADDR_W.
- Address: `rd_addr` = (`base` + `idx`·z) mod 2^ADDR_W.
  - z is a power of two, so `idx`·z is a left shift.
  - The product is WIN_W+ZMAX_LOG bits wide; the sum is truncated to ADDR_W.
- IDLE → RUN on `start`=1 and `abort`=0.
  - Latch z, `base`; set `idx`=0; `rd_addr`=`base`.
- RUN, beat accepted (`rd_valid` & `rd_ready`):
  - `idx` < 2^WIN_W−1: `idx`+1, `rd_addr`+z (mod 2^ADDR_W).
  - `idx` = 2^WIN_W−1: → DONE.
- RUN, `rd_ready`=0: `rd_addr` and `idx` hold.
- DONE, always exactly one cycle:
  - `cont`=1 (sampled in DONE): → RUN. Re-latch `zoom`, `offset`, `trig_addr`; `idx`=0.
  - Otherwise: → IDLE.
- `abort`=1 in RUN or DONE: → IDLE next cycle.
  - `rd_valid`=0, `done` not asserted.
  - `abort` has priority over accept, `start` and `cont`.
- `start` in RUN/DONE is ignored.
- `zoom`/`offset`/`trig_addr` changes mid-frame have no effect.

## Timing
- Reset values: state IDLE, `rd_addr`=0, `rd_valid`=0, `idx`=0, `busy`=0, `done`=0. Reset asserted mid-frame forces these immediately, with no `done`.
- All outputs are registered; no combinational path from inputs to outputs.
- Start latency: `start` sampled at edge k → `rd_valid`=1 with `rd_addr`=`base` after edge k.
- Throughput: one address per cycle while `rd_ready`=1, i.e. 2^WIN_W cycles per frame.
- Frame end:
  - Last accept at edge m → `done`=1, `rd_valid`=0 after edge m.
  - After edge m+1: IDLE, or RUN with `idx`=0 if `cont`.
  - In continuous mode this leaves exactly one bubble between frames.
- Handshake: `rd_addr` and `idx` are stable while `rd_valid`=1 and `rd_ready`=0.

## Test plan
Defaults for all cases: ADDR_W=13, WIN_W=10, OFF_SHIFT=8.
- Plain frame: `zoom`=1, `offset`=0, `trig_addr`=0, `rd_ready`=1.
  - Addresses 0..1023 on consecutive cycles.
  - `done` one cycle after the 1023 accept; `busy` high for 1025 cycles.
- Trigger, offset and wrap: `zoom`=4, `offset`=3, `trig_addr`=0x1F00.
  - First `rd_addr`=0x0200 (0x2200 wrapped); second 0x0204; last (`idx`=1023) 0x11FC.
- Illegal zoom: `zoom`=5 and `zoom`=0 → step 1. `zoom`=8, `trig_addr`=0x1000 → last address 0x0FF8.
- Back-pressure: `rd_ready`=0 for 3 cycles while `idx`=10, `zoom`=2, `base`=0.
  - `rd_addr`=20 and `idx`=10 held for 3 cycles, then 22 / 11.
  - Frame still ends with `idx`=1023 and exactly one `done`.
- Abort and reset mid-frame:
  - `abort` at `idx`=500 → IDLE next cycle, no `done`; a new `start` restarts at `idx`=0.
  - `rst_n` low at `idx`=300 → all outputs at reset values immediately.
- Continuous mode: `cont`=1; `zoom` changed 1→2 mid-frame.
  - Change is ignored until the frame end.
  - One-cycle `done`/bubble, then the next frame starts at `base` with step 2.
  - `start` pulses during RUN have no effect.
